mul_seq_hs: RTL and testbench

//  Parametrised iterative multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned per operation.

---
 rtl/mul_seq_hs.sv | 101 ++++++++++
 tb/tb_mul_seq_hs.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_hs.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per beat, valid/ready on both sides.
// Optional MUL_EARLY_TERM_EN ends an operation as soon as the remaining multiplier bits are all zero.
module mul_seq_hs #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] ma;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   mb_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CW-1:0]      counter;
    logic               sign_neg;
    logic               accept;
    logic               last_step;

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept    = in_valid && in_ready;
        busy      = (state == BUSY);
        out_valid = (state == DONE);
        mag_a     = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b     = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        // ma is pre-shifted each step, so adding it equals |a| << (WIDTH-counter)
        acc_next  = acc + (mb[0] ? ma : '0);
        mb_next   = mb >> 1;
`ifdef MUL_EARLY_TERM_EN
        last_step = (counter == CW'(1)) || (mb_next == '0);
`else
        last_step = (counter == CW'(1));
`endif
        prod_next = sign_neg ? -acc_next : acc_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_step) state_next = DONE;
            DONE: begin
                if (accept)         state_next = BUSY;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ma       <= '0;
            mb       <= '0;
            acc      <= '0;
            counter  <= '0;
            sign_neg <= 1'b0;
            out_p    <= '0;
        end else if (accept) begin
            sign_neg <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            ma       <= {{WIDTH{1'b0}}, mag_a};
            mb       <= mag_b;
            acc      <= '0;
            counter  <= CW'(WIDTH);
        end else if (state == BUSY) begin
            acc     <= acc_next;
            ma      <= ma << 1;
            mb      <= mb_next;
            counter <= counter - CW'(1);
            if (last_step) out_p <= prod_next;
        end
    end

endmodule

// File: tb/tb_mul_seq_hs.sv
// Scoreboard bench for mul_seq_hs: directed corner cases plus randomized beats with stalls on both handshakes.
// Expected products and latencies come from plain integer arithmetic; honours MUL_EARLY_TERM_EN for latency.
module tb_mul_seq_hs;

    localparam int W = 16;

    typedef struct {
        logic [2*W-1:0] p;
        int             lat;
        int             acc;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    logic rand_mode;
    logic rand_ready;
    logic dir_ready;
    logic prev_valid;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    assign out_ready = rand_mode ? rand_ready : dir_ready;

    mul_seq_hs #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        rand_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rand_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] refMul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sb2;
        logic [63:0] pr;
        sa  = s ? longint'($signed(a)) : longint'(a);
        sb2 = s ? longint'($signed(b)) : longint'(b);
        pr  = sa * sb2;
        return pr[2*W-1:0];
    endfunction

    function automatic int refLat(input logic s, input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
        logic [W-1:0] mag;
        int           lat;
        mag = (s && b[W-1]) ? -b : b;
        lat = 1;
        for (int i = 0; i < W; i++)
            if (mag[i]) lat = i + 1;
        return lat;
`else
        return W;
`endif
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   done;
        done      = 0;
        in_valid  = 1'b1;
        in_signed = s;
        in_a      = a;
        in_b      = b;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.p   = refMul(s, a, b);
                e.lat = refLat(s, b);
                e.acc = cyc + 1;
                sb.push_back(e);
                done  = 1;
            end
        end
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_signed = 1'($urandom);
    endtask

    task automatic waitDrain();
        bit done;
        done = 0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on first valid cycle, product on every valid cycle, pop on handshake.
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("spurious_valid", 64'd1, 64'd0);
                    end else begin
                        if (!prev_valid) checkOutput("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                        checkOutput("product", 64'(out_p), 64'(sb[0].p));
                        checkOutput("busy_in_done", 64'(busy), 64'd0);
                        if (!out_ready) checkOutput("in_ready_stall", 64'(in_ready), 64'd0);
                        else void'(sb.pop_front());
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_a        = '0;
        in_b        = '0;
        dir_ready   = 1'b1;
        rand_mode   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_p", 64'(out_p), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] directed unsigned and signed corners");
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
        waitDrain();
        applyStimulus(1'b1, 16'h8000, 16'h8000);
        waitDrain();
        applyStimulus(1'b1, 16'hFFFF, 16'h0001);
        waitDrain();
        applyStimulus(1'b1, 16'h8000, 16'h7FFF);
        waitDrain();

        $display("[TB] output stall then same-edge accept");
        dir_ready = 1'b0;
        applyStimulus(1'b0, 16'h00FF, 16'h0101);
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        checkOutput("stall_reached_valid", 64'(out_valid), 64'd1);
        repeat (5) @(posedge clk);
        #1 dir_ready = 1'b1;
        applyStimulus(1'b0, 16'h0003, 16'h0005);
        @(negedge clk);
        checkOutput("b2b_busy", 64'(busy), 64'd1);
        checkOutput("b2b_out_valid", 64'(out_valid), 64'd0);
        waitDrain();

        $display("[TB] reset during busy");
        applyStimulus(1'b1, 16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_p", 64'(out_p), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        repeat (W + 4) @(posedge clk);
        #1;

        $display("[TB] data-dependent latency cases");
        applyStimulus(1'b0, 16'h1234, 16'h0003);
        waitDrain();
        applyStimulus(1'b1, 16'h1234, 16'h0000);
        waitDrain();

        $display("[TB] randomized beats with handshake stalls");
        rand_mode = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            case ($urandom_range(0, 7))
                0:       applyStimulus(1'($urandom), 16'h8000, W'($urandom));
                1:       applyStimulus(1'($urandom), W'($urandom), 16'h0000);
                2:       applyStimulus(1'($urandom), 16'hFFFF, W'($urandom_range(0, 15)));
                default: applyStimulus(1'($urandom), W'($urandom), W'($urandom));
            endcase
        end
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
